if_id_pipe_reg: RTL and testbench
=================================

// Module: if_id_pipe_reg
// PURPOSE
//  Parametrised IF/ID pipeline register for the RISC-V pipeline; successor to the plain PC/instruction latch.
//  Adds valid/ready handshake, optional 2-entry skid buffer so in_ready is fully registered,
//  synchronous flush with NOP bubble for branch/jump redirects, and PC+4 pass-through.
//  Sits between the fetch unit (producer) and the decode stage (consumer).
// PARAMETERS
//  XLEN      32            PC width in bits
//  ILEN      32            instruction width in bits
//  SKID      1             1 = 2-entry skid buffer, registered in_ready; 0 = single entry, combinational in_ready
//  NOP_INSTR 32'h00000013  instruction driven when empty/flushed (addi x0,x0,0)
// PORTS
//  clk              input   1     rising-edge clock
//  reset            input   1     asynchronous, active-low reset
//  in_valid         input   1     fetch presents PC_in/instruction_in
//  in_ready         output  1     stage can accept; transfer = in_valid & in_ready
//  PC_in            input   XLEN  fetched PC
//  instruction_in   input   ILEN  fetched instruction
//  flush            input   1     discard all held entries (redirect)
//  out_valid        output  1     PC_out/instruction_out hold a live instruction
//  out_ready        input   1     decode consumes; transfer = out_valid & out_ready
//  PC_out           output  XLEN  PC of head entry
//  PC4_out          output  XLEN  PC_out + 4, modulo 2^XLEN
//  instruction_out  output  ILEN  head instruction, NOP_INSTR when !out_valid
// BEHAVIOUR
//  Reset (reset=0, async): out_valid=0, PC_out=0, PC4_out=4, instruction_out=NOP_INSTR,
//   in_ready=1, state EMPTY; skid contents cleared. Release takes effect at next clk edge.
//  Latency: accepted entry appears on outputs the cycle after the accept edge (1 cycle).
//  State machine (SKID=1), on each rising edge, acc=in_valid&in_ready, deq=out_valid&out_ready:
//   EMPTY: acc -> HEAD (load head).                                           else EMPTY.
//   HEAD : acc&deq -> HEAD (head<=in); acc&!deq -> FULL (load skid); !acc&deq -> EMPTY; else HEAD.
//   FULL : deq -> HEAD (head<=skid).  in_ready=0 in FULL, so acc is impossible. else FULL.
//  in_ready (SKID=1) = (state != FULL), a flop output; no combinational path from out_ready.
//  SKID=0: states EMPTY/HEAD only; in_ready = !out_valid | out_ready (combinational).
//  Order preserved: head always older than skid; no entry dropped or duplicated.
//  flush=1: next state EMPTY, both entries invalidated, instruction_out=NOP_INSTR, PC_out held;
//   flush has priority over a simultaneous accept (incoming entry dropped) and dequeue.
//   in_ready during flush cycle follows normal rule (producer redirect is fetch's job).
//  PC4_out is computed from the registered PC_out (combinational add), wraps 32'hFFFFFFFC -> 0.
//  When !out_valid the data outputs are don't-care for decode except instruction_out=NOP_INSTR.
//  Reset asserted mid-transfer: all held entries lost, outputs return to reset values immediately.
// STRUCTURE
//  Shared package riscv_pipe_pkg: NOP_INSTR constant, XLEN/ILEN defaults, state encoding
//   localparams (ST_EMPTY=2'd0, ST_HEAD=2'd1, ST_FULL=2'd2).
//  One natural sub-module: pipe_skid_buf (generic WIDTH-bit 2-entry elastic buffer);
//   if_id_pipe_reg packs {PC,instruction} into it, adds flush, NOP substitution and PC+4.
// TESTING
//  1 reset=0 for 2 cycles -> out_valid=0, instruction_out=00000013, PC4_out=4, in_ready=1.
//  2 release; in_valid=1 PC_in=4 instr=00500093, out_ready=1 -> next cycle out_valid=1, PC_out=4,
//    PC4_out=8, instruction_out=00500093; then PC_in=8 instr=002081b3 streams one per cycle.
//  3 out_ready=0, push PC=C lw 0000a283 then PC=10 -> state FULL, in_ready=0; out_ready=1 ->
//    PC_out=C then 10 in order, in_ready=1 after first dequeue.
//  4 FULL with in_valid=1 and flush=1 -> next cycle out_valid=0, instruction_out=00000013,
//    in_ready=1; dropped entries never appear.
//  5 PC_in=FFFFFFFC accepted -> PC4_out=00000000.
//  6 async reset=0 mid-cycle while FULL -> outputs return to reset values without clk edge;
//    SKID=0 build repeats scenarios 2-4 with in_ready tracking out_ready combinationally.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the RISC-V pipeline registers: default widths,
// the canonical NOP encoding and the elastic-buffer state encoding.
package riscv_pipe_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned ILEN_DEF = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef logic [1:0] pipe_state_t;

  localparam pipe_state_t ST_EMPTY = 2'd0;
  localparam pipe_state_t ST_HEAD  = 2'd1;
  localparam pipe_state_t ST_FULL  = 2'd2;

  // Occupancy transition of a 1- or 2-entry elastic buffer.
  // flush wins over any simultaneous accept or dequeue. With skid_en=0 the
  // buffer never enters FULL (a single-entry stage only accepts when the
  // head is leaving or absent).
  function automatic pipe_state_t pipe_next_state(
    input pipe_state_t st,
    input logic        acc,
    input logic        deq,
    input logic        flush,
    input logic        skid_en
  );
    pipe_state_t nxt;
    nxt = st;
    if (flush) begin
      nxt = ST_EMPTY;
    end else begin
      case (st)
        ST_EMPTY: begin
          if (acc) nxt = ST_HEAD;
        end
        ST_HEAD: begin
          if (acc && !deq)      nxt = skid_en ? ST_FULL : ST_HEAD;
          else if (!acc && deq) nxt = ST_EMPTY;
        end
        ST_FULL: begin
          if (deq) nxt = ST_HEAD;
        end
        default: nxt = ST_EMPTY;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic WIDTH-bit elastic buffer with valid/ready on both sides.
// SKID=1: head + skid entry, o_ready comes straight from a flop.
// SKID=0: head entry only, o_ready = !o_valid | i_ready (combinational).
// Synchronous flush drops every held entry; data registers keep their
// contents so the head data stays visible while o_valid is low.
module pipe_skid_buf #(
  parameter int unsigned WIDTH = 64,
  parameter bit          SKID  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);
  import riscv_pipe_pkg::*;

  pipe_state_t      r_state;
  pipe_state_t      w_state_nxt;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_skid;
  logic             w_acc;
  logic             w_deq;

  assign o_valid = (r_state != ST_EMPTY);
  assign o_data  = r_head;
  assign w_acc   = i_valid & o_ready;
  assign w_deq   = o_valid & i_ready;

  // Next occupancy state from handshake and flush
  always_comb begin
    w_state_nxt = pipe_next_state(r_state, w_acc, w_deq, i_flush, SKID);
  end

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Entry storage: head is always the older entry, skid the younger one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_skid <= '0;
    end else if (!i_flush) begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) r_head <= i_data;
        end
        ST_HEAD: begin
          if (w_acc && w_deq) r_head <= i_data;
          else if (w_acc)     r_skid <= i_data;
        end
        ST_FULL: begin
          if (w_deq) r_head <= r_skid;
        end
        default: ;
      endcase
    end
  end

  generate
    if (SKID) begin : g_skid
      logic r_in_ready;

      // Registered ready: precomputed from the next state so there is no
      // path from i_ready to o_ready
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_in_ready <= 1'b1;
        else        r_in_ready <= (w_state_nxt != ST_FULL);
      end

      assign o_ready = r_in_ready;
    end else begin : g_noskid
      assign o_ready = ~o_valid | i_ready;
    end
  endgenerate

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: {PC, instruction} held in an elastic buffer,
// NOP substituted whenever no live instruction is presented, and PC+4
// derived from the registered head PC.
module if_id_pipe_reg #(
  parameter int unsigned         XLEN      = riscv_pipe_pkg::XLEN_DEF,
  parameter int unsigned         ILEN      = riscv_pipe_pkg::ILEN_DEF,
  parameter bit                  SKID      = 1'b1,
  parameter logic [ILEN-1:0]     NOP_INSTR = ILEN'(riscv_pipe_pkg::NOP_INSTR)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] PC_in,
  input  logic [ILEN-1:0] instruction_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] PC_out,
  output logic [XLEN-1:0] PC4_out,
  output logic [ILEN-1:0] instruction_out
);
  localparam int unsigned W = XLEN + ILEN;

  logic [W-1:0] w_in_data;
  logic [W-1:0] w_head;
  logic         w_valid;

  assign w_in_data = {PC_in, instruction_in};

  pipe_skid_buf #(
    .WIDTH (W),
    .SKID  (SKID)
  ) u_buf (
    .clk     (clk),
    .rst_n   (reset),
    .i_flush (flush),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_in_data),
    .o_valid (w_valid),
    .i_ready (out_ready),
    .o_data  (w_head)
  );

  assign out_valid       = w_valid;
  assign PC_out          = w_head[W-1:ILEN];
  assign instruction_out = w_valid ? w_head[ILEN-1:0] : NOP_INSTR;
  assign PC4_out         = PC_out + XLEN'(4);

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: a SKID=1 and a SKID=0 instance side by side,
// directed scenarios plus randomized traffic against a queue model.
module tb_if_id_pipe_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       iv, ordy, fl;
  logic [1:0][31:0] pci, ini;
  wire  [1:0]       ir, ov;
  wire  [1:0][31:0] pco, pc4o, io;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  if_id_pipe_reg #(.XLEN(32), .ILEN(32), .SKID(1'b1), .NOP_INSTR(32'h0000_0013)) u_skid (
    .clk(clk), .reset(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .PC_in(pci[0]),
    .instruction_in(ini[0]), .flush(fl[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .PC_out(pco[0]), .PC4_out(pc4o[0]), .instruction_out(io[0]));

  if_id_pipe_reg #(.XLEN(32), .ILEN(32), .SKID(1'b0), .NOP_INSTR(32'h0000_0013)) u_single (
    .clk(clk), .reset(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .PC_in(pci[1]),
    .instruction_in(ini[1]), .flush(fl[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .PC_out(pco[1]), .PC4_out(pc4o[1]), .instruction_out(io[1]));

  // Reference model: FIFO contents per instance, capacity 2 (d=0) or 1 (d=1)
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq [2][2];
  int unsigned mcnt [2];
  logic [31:0] mlast [2];

  function automatic logic m_ready(input int d);
    if (d == 0) return (mcnt[0] < 2);
    return (mcnt[1] == 0) || ordy[1];
  endfunction

  function automatic logic m_valid(input int d);
    return mcnt[d] != 0;
  endfunction

  function automatic logic [31:0] m_pc(input int d);
    return (mcnt[d] != 0) ? mq[d][0].pc : mlast[d];
  endfunction

  function automatic logic [31:0] m_ins(input int d);
    return (mcnt[d] != 0) ? mq[d][0].ins : NOP;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      mcnt[d]  = 0;
      mlast[d] = 32'h0;
    end
  endfunction

  function automatic void model_edge(input int d);
    logic acc, deq;
    acc = iv[d] && m_ready(d);
    deq = m_valid(d) && ordy[d];
    mlast[d] = m_pc(d);
    if (fl[d]) begin
      mcnt[d] = 0;
    end else begin
      if (deq) begin
        mq[d][0] = mq[d][1];
        mcnt[d]  = mcnt[d] - 1;
      end
      if (acc) begin
        mq[d][mcnt[d]] = {pci[d], ini[d]};
        mcnt[d]        = mcnt[d] + 1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else for (int d = 0; d < 2; d++) model_edge(d);
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input logic r, input logic f,
                        input logic [31:0] pc, input logic [31:0] ins);
    iv = {v, v}; ordy = {r, r}; fl = {f, f};
    pci[0] = pc; pci[1] = pc; ini[0] = ins; ini[1] = ins;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (ov[d] !== 1'b0) begin n_fail++; $display("FAIL reset_valid dut%0d got %b want 0", d, ov[d]); end
      n_checks++; if (io[d] !== NOP) begin n_fail++; $display("FAIL reset_instr dut%0d got %h want %h", d, io[d], NOP); end
      n_checks++; if (pc4o[d] !== 32'h4) begin n_fail++; $display("FAIL reset_pc4 dut%0d got %h want 4", d, pc4o[d]); end
      n_checks++; if (pco[d] !== 32'h0) begin n_fail++; $display("FAIL reset_pc dut%0d got %h want 0", d, pco[d]); end
      n_checks++; if (ir[d] !== 1'b1) begin n_fail++; $display("FAIL reset_ready dut%0d got %b want 1", d, ir[d]); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    set_in(1'b1, 1'b1, 1'b0, 32'h4, 32'h0050_0093);
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (ov[d] !== 1'b1) begin n_fail++; $display("FAIL stream_valid dut%0d got %b want 1", d, ov[d]); end
      n_checks++; if (pco[d] !== 32'h4) begin n_fail++; $display("FAIL stream_pc dut%0d got %h want 4", d, pco[d]); end
      n_checks++; if (pc4o[d] !== 32'h8) begin n_fail++; $display("FAIL stream_pc4 dut%0d got %h want 8", d, pc4o[d]); end
      n_checks++; if (io[d] !== 32'h0050_0093) begin n_fail++; $display("FAIL stream_instr dut%0d got %h want 00500093", d, io[d]); end
    end
    set_in(1'b1, 1'b1, 1'b0, 32'h8, 32'h0020_81b3);
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (pco[d] !== 32'h8) begin n_fail++; $display("FAIL stream2_pc dut%0d got %h want 8", d, pco[d]); end
      n_checks++; if (io[d] !== 32'h0020_81b3) begin n_fail++; $display("FAIL stream2_instr dut%0d got %h want 002081b3", d, io[d]); end
      n_checks++; if (ir[d] !== 1'b1) begin n_fail++; $display("FAIL stream2_ready dut%0d got %b want 1", d, ir[d]); end
    end
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (ov[d] !== 1'b0) begin n_fail++; $display("FAIL drain_valid dut%0d got %b want 0", d, ov[d]); end
      n_checks++; if (io[d] !== NOP) begin n_fail++; $display("FAIL drain_instr dut%0d got %h want %h", d, io[d], NOP); end
    end
  endtask

  task automatic test_backpressure();
    set_in(1'b1, 1'b0, 1'b0, 32'hC, 32'h0000_a283);
    tick();
    n_checks++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL bp_ready_head dut0 got %b want 1", ir[0]); end
    n_checks++; if (ir[1] !== 1'b0) begin n_fail++; $display("FAIL bp_ready_head dut1 got %b want 0", ir[1]); end
    set_in(1'b1, 1'b0, 1'b0, 32'h10, 32'h00c1_2023);
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (ir[d] !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full dut%0d got %b want 0", d, ir[d]); end
      n_checks++; if (pco[d] !== 32'hC) begin n_fail++; $display("FAIL bp_pc_first dut%0d got %h want c", d, pco[d]); end
      n_checks++; if (io[d] !== 32'h0000_a283) begin n_fail++; $display("FAIL bp_instr_first dut%0d got %h want 0000a283", d, io[d]); end
    end
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    n_checks++; if (ir[1] !== 1'b1) begin n_fail++; $display("FAIL bp_comb_ready dut1 got %b want 1", ir[1]); end
    n_checks++; if (ir[0] !== 1'b0) begin n_fail++; $display("FAIL bp_reg_ready dut0 got %b want 0", ir[0]); end
    tick();
    n_checks++; if (pco[0] !== 32'h10) begin n_fail++; $display("FAIL bp_pc_second dut0 got %h want 10", pco[0]); end
    n_checks++; if (io[0] !== 32'h00c1_2023) begin n_fail++; $display("FAIL bp_instr_second dut0 got %h want 00c12023", io[0]); end
    n_checks++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after dut0 got %b want 1", ir[0]); end
    n_checks++; if (ov[1] !== 1'b0) begin n_fail++; $display("FAIL bp_single_empty dut1 got %b want 0", ov[1]); end
    tick();
    n_checks++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL bp_drained dut0 got %b want 0", ov[0]); end
  endtask

  task automatic test_flush();
    set_in(1'b1, 1'b0, 1'b0, 32'h20, 32'h0010_0093);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 32'h24, 32'h0020_0113);
    tick();
    set_in(1'b1, 1'b0, 1'b1, 32'h28, 32'h0030_0193);
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (ov[d] !== 1'b0) begin n_fail++; $display("FAIL flush_valid dut%0d got %b want 0", d, ov[d]); end
      n_checks++; if (io[d] !== NOP) begin n_fail++; $display("FAIL flush_instr dut%0d got %h want %h", d, io[d], NOP); end
      n_checks++; if (ir[d] !== 1'b1) begin n_fail++; $display("FAIL flush_ready dut%0d got %b want 1", d, ir[d]); end
      n_checks++; if (pco[d] !== 32'h20) begin n_fail++; $display("FAIL flush_pc_held dut%0d got %h want 20", d, pco[d]); end
    end
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_checks++; if (ov[d] !== 1'b0) begin n_fail++; $display("FAIL flush_no_ghost dut%0d cyc%0d got %b want 0", d, k, ov[d]); end
      end
    end
  endtask

  task automatic test_wrap();
    set_in(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0010_0113);
    tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (pco[d] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc dut%0d got %h want fffffffc", d, pco[d]); end
      n_checks++; if (pc4o[d] !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4 dut%0d got %h want 0", d, pc4o[d]); end
    end
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_async_reset();
    set_in(1'b1, 1'b0, 1'b0, 32'h40, 32'h0040_0213);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 32'h44, 32'h0050_0293);
    tick();
    n_checks++; if (ir[0] !== 1'b0) begin n_fail++; $display("FAIL areset_full dut0 got %b want 0", ir[0]); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (ov[d] !== 1'b0) begin n_fail++; $display("FAIL areset_valid dut%0d got %b want 0", d, ov[d]); end
      n_checks++; if (io[d] !== NOP) begin n_fail++; $display("FAIL areset_instr dut%0d got %h want %h", d, io[d], NOP); end
      n_checks++; if (pco[d] !== 32'h0) begin n_fail++; $display("FAIL areset_pc dut%0d got %h want 0", d, pco[d]); end
      n_checks++; if (pc4o[d] !== 32'h4) begin n_fail++; $display("FAIL areset_pc4 dut%0d got %h want 4", d, pc4o[d]); end
    end
    n_checks++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL areset_ready dut0 got %b want 1", ir[0]); end
    tick();
    rst_n = 1'b1;
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      for (int d = 0; d < 2; d++) begin
        iv[d]   = ($urandom_range(0, 3) != 0);
        ordy[d] = ($urandom_range(0, 2) != 0);
        fl[d]   = ($urandom_range(0, 15) == 0);
        pci[d]  = ($urandom_range(0, 20) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
        ini[d]  = $urandom();
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        n_checks++; if (ov[d] !== m_valid(d)) begin n_fail++; $display("FAIL rnd_valid dut%0d cyc%0d got %b want %b", d, k, ov[d], m_valid(d)); end
        n_checks++; if (ir[d] !== m_ready(d)) begin n_fail++; $display("FAIL rnd_ready dut%0d cyc%0d got %b want %b", d, k, ir[d], m_ready(d)); end
        n_checks++; if (pco[d] !== m_pc(d)) begin n_fail++; $display("FAIL rnd_pc dut%0d cyc%0d got %h want %h", d, k, pco[d], m_pc(d)); end
        n_checks++; if (pc4o[d] !== m_pc(d) + 32'd4) begin n_fail++; $display("FAIL rnd_pc4 dut%0d cyc%0d got %h want %h", d, k, pc4o[d], m_pc(d) + 32'd4); end
        n_checks++; if (io[d] !== m_ins(d)) begin n_fail++; $display("FAIL rnd_instr dut%0d cyc%0d got %h want %h", d, k, io[d], m_ins(d)); end
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    model_reset();
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
